// File: rtl/chess_ctrl_slave.sv
// Avalon-MM control slave for the chess accelerator: CTRL/STATUS/RESULT registers, board RAM and engine handshake.
// Optional macro CHESS_CTRL_IRQ_EN adds the irq output and a writable IRQ_ENABLE bit.
module chess_ctrl_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [DATA_WIDTH-1:0]   slave_writedata,
  input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
  output logic [DATA_WIDTH-1:0]   slave_readdata,
  output logic                    slave_readdatavalid,
  output logic                    eng_start,
  input  logic                    eng_done,
  input  logic [DATA_WIDTH-1:0]   eng_result,
  input  logic [ADDR_WIDTH-1:0]   eng_rd_addr,
  output logic [DATA_WIDTH-1:0]   eng_rd_data
`ifdef CHESS_CTRL_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 2**ADDR_WIDTH - 4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t                  r_state, w_nextState;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
  logic                    r_done, r_overrun;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [DATA_WIDTH-1:0]   r_engRd;
  logic [READ_LATENCY-1:0] r_pv;
  logic [DATA_WIDTH-1:0]   r_pd [READ_LATENCY];

  logic                    w_busy, w_irqEn;
  logic                    w_isRam, w_engIsRam;
  logic [ADDR_WIDTH-1:0]   w_ramIdx, w_engIdx;
  logic                    w_ctrlWr, w_statWr, w_go, w_engFinish;
  logic [DATA_WIDTH-1:0]   w_rdData;

  assign w_isRam     = slave_address >= ADDR_WIDTH'(4);
  assign w_ramIdx    = slave_address - ADDR_WIDTH'(4);
  assign w_engIsRam  = eng_rd_addr >= ADDR_WIDTH'(4);
  assign w_engIdx    = eng_rd_addr - ADDR_WIDTH'(4);
  assign w_ctrlWr    = slave_write && (slave_address == ADDR_WIDTH'(0));
  assign w_statWr    = slave_write && (slave_address == ADDR_WIDTH'(1));
  assign w_go        = w_ctrlWr && slave_byteenable[0] && slave_writedata[0];
  assign w_engFinish = (r_state == S_RUN) && eng_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    eng_start   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_go) w_nextState = S_START;
      S_START: begin
        eng_start   = 1'b1;
        w_busy      = 1'b1;
        w_nextState = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (eng_done) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Sticky status bits: a hardware set takes priority over a host W1C in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_engFinish) begin
        r_done   <= 1'b1;
        r_result <= eng_result;
      end else if (w_statWr && slave_byteenable[0] && slave_writedata[1]) begin
        r_done <= 1'b0;
      end
      if (w_go && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      else if (w_statWr && slave_byteenable[0] && slave_writedata[2])
        r_overrun <= 1'b0;
    end
  end

`ifdef CHESS_CTRL_IRQ_EN
  logic r_irqEn, r_irq;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqEn <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_ctrlWr && slave_byteenable[0]) r_irqEn <= slave_writedata[1];
      r_irq <= r_irqEn && r_done;
    end
  end
  assign w_irqEn = r_irqEn;
  assign irq     = r_irq;
`else
  assign w_irqEn = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (slave_write && w_isRam) begin
      for (int b = 0; b < NBYTES; b++)
        if (slave_byteenable[b]) r_mem[w_ramIdx][b*8 +: 8] <= slave_writedata[b*8 +: 8];
    end
  end

  always_comb begin
    w_rdData = '0;
    if (w_isRam) begin
      w_rdData = r_mem[w_ramIdx];
    end else begin
      case (slave_address[1:0])
        2'd0: w_rdData[1] = w_irqEn;
        2'd1: w_rdData[2:0] = {r_overrun, r_done, w_busy};
        2'd2: w_rdData = r_result;
        default: w_rdData = '0;
      endcase
    end
  end

  // Each data stage only advances with a valid beat, so the last stage holds the previous read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
      r_engRd <= '0;
    end else begin
      r_pv[0] <= slave_read;
      if (slave_read) r_pd[0] <= w_rdData;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
      r_engRd <= w_engIsRam ? r_mem[w_engIdx] : '0;
    end
  end

  assign slave_readdatavalid = r_pv[READ_LATENCY-1];
  assign slave_readdata      = r_pd[READ_LATENCY-1];
  assign eng_rd_data         = r_engRd;

endmodule
